// File: rtl/hilo_muldiv.sv
// hilo_muldiv: sequential multiply/divide unit owning the architectural HI/LO pair.
// Iterative ops (MULT/MULTU/MADD/MADDU/DIV/DIVU) run 32 iterations through a
// start/busy/done handshake; MTHI/MTLO and rejected divides retire in one cycle.
// Define HILO_MULDIV_DIV_EN to build the restoring divider; without it DIV/DIVU
// always retire immediately with div_by_zero set and HI/LO untouched.

module hilo_muldiv #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

   // Codes 0/1 (MULT/MULTU) fall through to the plain-product path.
   localparam logic [2:0] OpMadd  = 3'd2;
   localparam logic [2:0] OpMaddu = 3'd3;
   localparam logic [2:0] OpDiv   = 3'd4;
   localparam logic [2:0] OpDivu  = 3'd5;
   localparam logic [2:0] OpMthi  = 3'd6;
   localparam logic [2:0] OpMtlo  = 3'd7;

   typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

   state_e             state_q;
   logic [CW-1:0]      cnt_q;
   logic [2:0]         op_q;
   logic [2*WIDTH-1:0] acc_q;      // {partial product} or {remainder, quotient}
   logic [WIDTH-1:0]   opnd_q;     // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               neg_res_q;  // negate product / quotient at fix-up
   logic               done_q, dbz_q;

   logic               is_signed, is_div, div_reject;
   logic [WIDTH-1:0]   abs_a, abs_b, opnd_init, res_hi, res_lo;
   logic [2*WIDTH-1:0] acc_init, step_next, prod_fix, madd_sum;
   logic [WIDTH:0]     mul_sum;
`ifdef HILO_MULDIV_DIV_EN
   logic               neg_rem_q;  // remainder follows dividend sign
   logic [WIDTH:0]     div_shift;
   logic [WIDTH-1:0]   div_trial, quo_fix, rem_fix;
`endif

   // Accept-time decode: operand magnitudes and initial datapath contents
   always_comb begin
      is_signed = (op == 3'd0) || (op == OpMadd) || (op == OpDiv);
      is_div    = (op == OpDiv) || (op == OpDivu);
      abs_a     = (is_signed && a[WIDTH-1]) ? -a : a;
      abs_b     = (is_signed && b[WIDTH-1]) ? -b : b;
      acc_init  = {{WIDTH{1'b0}}, abs_b};
      opnd_init = abs_a;
`ifdef HILO_MULDIV_DIV_EN
      div_reject = is_div && (b == '0);
      if (is_div) begin
         acc_init  = {{WIDTH{1'b0}}, abs_a};
         opnd_init = abs_b;
      end
`else
      div_reject = is_div;
`endif
   end

   // One iteration of the shift-add multiplier or the restoring divider
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & opnd_q};
      step_next = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef HILO_MULDIV_DIV_EN
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      // Only meaningful when div_shift >= divisor, where it fits in WIDTH bits
      div_trial = div_shift[WIDTH-1:0] - opnd_q;
      if ((op_q == OpDiv) || (op_q == OpDivu)) begin
         if (div_shift >= {1'b0, opnd_q}) begin
            step_next = {div_trial, acc_q[WIDTH-2:0], 1'b1};
         end else begin
            step_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
         end
      end
`endif
   end

   // Result fix-up: apply result signs and accumulate for MADD/MADDU
   always_comb begin
      prod_fix = neg_res_q ? -acc_q : acc_q;
      madd_sum = {hi_q, lo_q} + prod_fix;
      {res_hi, res_lo} = prod_fix;
      if ((op_q == OpMadd) || (op_q == OpMaddu)) begin
         {res_hi, res_lo} = madd_sum;
      end
`ifdef HILO_MULDIV_DIV_EN
      quo_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      if ((op_q == OpDiv) || (op_q == OpDivu)) begin
         res_hi = rem_fix;
         res_lo = quo_fix;
      end
`endif
   end

   // Control FSM, iteration datapath and architectural HI/LO registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         op_q      <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         neg_res_q <= 1'b0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
`ifdef HILO_MULDIV_DIV_EN
         neg_rem_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  if (op == OpMthi) begin
                     hi_q   <= a;
                     done_q <= 1'b1;
                  end else if (op == OpMtlo) begin
                     lo_q   <= a;
                     done_q <= 1'b1;
                  end else if (div_reject) begin
                     done_q <= 1'b1;
                     dbz_q  <= 1'b1;
                  end else begin
                     op_q      <= op;
                     acc_q     <= acc_init;
                     opnd_q    <= opnd_init;
                     neg_res_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef HILO_MULDIV_DIV_EN
                     neg_rem_q <= is_signed & a[WIDTH-1];
`endif
                     cnt_q     <= '0;
                     state_q   <= StRun;
                  end
               end
            end
            StRun: begin
               acc_q <= step_next;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LastIter) begin
                  state_q <= StFix;
               end
            end
            StFix: begin
               hi_q    <= res_hi;
               lo_q    <= res_lo;
               done_q  <= 1'b1;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy        = (state_q != StIdle);
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: randomized self-checking bench for hilo_muldiv against an
// arithmetic model of HI/LO. Divide checks adapt to HILO_MULDIV_DIV_EN.

module tb_hilo_muldiv;

   logic        clk, reset, start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [31:0] hi_m, lo_m;
   logic        dbz_m;

`ifdef HILO_MULDIV_DIV_EN
   localparam bit DivEn = 1'b1;
`else
   localparam bit DivEn = 1'b0;
`endif

   hilo_muldiv #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   // Reference model: HI/LO behaviour from plain 64-bit arithmetic
   task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      int          sx, sy;
      longint      sp;
      logic [63:0] up;
      sx = x;
      sy = y;
      sp = longint'(sx) * longint'(sy);
      up = {32'b0, x} * {32'b0, y};
      dbz_m = 1'b0;
      case (o)
         3'd0: {hi_m, lo_m} = sp;
         3'd1: {hi_m, lo_m} = up;
         3'd2: {hi_m, lo_m} = {hi_m, lo_m} + 64'(sp);
         3'd3: {hi_m, lo_m} = {hi_m, lo_m} + up;
         3'd4: begin
            if (!DivEn || y == 0) dbz_m = 1'b1;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
               lo_m = x;
               hi_m = 32'h0;
            end else begin
               lo_m = 32'(sx / sy);
               hi_m = 32'(sx % sy);
            end
         end
         3'd5: begin
            if (!DivEn || y == 0) dbz_m = 1'b1;
            else begin
               lo_m = x / y;
               hi_m = x % y;
            end
         end
         3'd6: hi_m = x;
         default: lo_m = x;
      endcase
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: pick = 32'h0;
         1: pick = 32'h1;
         2: pick = 32'h8000_0000;
         3: pick = 32'hFFFF_FFFF;
         default: pick = $urandom;
      endcase
   endfunction

   // Present an op for one edge; operands are scrambled afterwards
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 3'($urandom);
      a     = $urandom;
      b     = $urandom;
   endtask

   // Cycles from accept edge until done, and cycles busy was seen high
   task automatic wait_done(output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      while (!done && lat < 100) begin
         if (busy) bcnt++;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int bcnt);
      issue(o, x, y);
      wait_done(lat, bcnt);
      model(o, x, y);
   endtask

   task automatic test_reset();
      int  lat, bc;
      bit  seen;
      reset = 1'b1;
      start = 1'b0;
      op = 3'd0; a = 32'h0; b = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, div_by_zero, hi, lo} !== 67'h0) begin
         n_fail++;
         $display("FAIL reset_values: got busy=%b done=%b dbz=%b hi=%h lo=%h want all 0",
                  busy, done, div_by_zero, hi, lo);
      end
      hi_m = 32'h0; lo_m = 32'h0;
      do_op(3'd6, $urandom | 32'h1, 32'h0, lat, bc);
      do_op(3'd7, $urandom | 32'h1, 32'h0, lat, bc);
      issue(3'd1, $urandom, $urandom);
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({busy, done, hi, lo} !== 66'h0) begin
         n_fail++;
         $display("FAIL reset_abort: got busy=%b done=%b hi=%h lo=%h want all 0",
                  busy, done, hi, lo);
      end
      hi_m = 32'h0; lo_m = 32'h0;
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done || busy) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_done: got activity=%b want 0", seen);
      end
   endtask

   task automatic test_mult();
      int          lat, bc;
      logic [2:0]  o;
      do_op(3'd0, 32'hFFFF_FFFD, 32'd7, lat, bc);
      n_cmp++;
      if (lat !== 33) begin
         n_fail++; $display("FAIL mult_latency: got %0d want 33", lat);
      end
      n_cmp++;
      if (bc !== 33) begin
         n_fail++; $display("FAIL mult_busy_cycles: got %0d want 33", bc);
      end
      n_cmp++;
      if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
         n_fail++; $display("FAIL mult_neg3x7: got %h_%h want ffffffff_ffffffeb", hi, lo);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (done !== 1'b0) begin
         n_fail++; $display("FAIL done_one_cycle: got %b want 0", done);
      end
      for (int i = 0; i < 12; i++) begin
         o = 3'($urandom_range(0, 1));
         do_op(o, pick(), pick(), lat, bc);
         n_cmp++;
         if ({lat, div_by_zero, hi, lo} !== {32'd33, 1'b0, hi_m, lo_m}) begin
            n_fail++;
            $display("FAIL mult_rand op=%0d: got lat=%0d dbz=%b %h_%h want lat=33 dbz=0 %h_%h",
                     o, lat, div_by_zero, hi, lo, hi_m, lo_m);
         end
      end
   endtask

   task automatic test_madd();
      int          lat, bc;
      logic [2:0]  o;
      do_op(3'd6, 32'h0, 32'h0, lat, bc);
      do_op(3'd7, 32'hFFFF_FFFF, 32'h0, lat, bc);
      do_op(3'd3, 32'h1, 32'h1, lat, bc);
      n_cmp++;
      if ({hi, lo} !== 64'h1_0000_0000) begin
         n_fail++; $display("FAIL maddu_carry: got %h_%h want 00000001_00000000", hi, lo);
      end
      for (int i = 0; i < 8; i++) begin
         o = 3'($urandom_range(2, 3));
         do_op(o, pick(), pick(), lat, bc);
         n_cmp++;
         if ({lat, hi, lo} !== {32'd33, hi_m, lo_m}) begin
            n_fail++;
            $display("FAIL madd_rand op=%0d: got lat=%0d %h_%h want lat=33 %h_%h",
                     o, lat, hi, lo, hi_m, lo_m);
         end
      end
   endtask

   task automatic test_div();
      int          lat, bc;
      logic [2:0]  o;
      logic [31:0] y;
`ifdef HILO_MULDIV_DIV_EN
      do_op(3'd4, 32'hFFFF_FFF9, 32'd2, lat, bc);
      n_cmp++;
      if ({lat, div_by_zero, hi, lo} !== {32'd33, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD}) begin
         n_fail++;
         $display("FAIL div_neg7_2: got lat=%0d dbz=%b hi=%h lo=%h want 33 0 ffffffff fffffffd",
                  lat, div_by_zero, hi, lo);
      end
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
      n_cmp++;
      if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
         n_fail++; $display("FAIL div_overflow: got hi=%h lo=%h want 0 80000000", hi, lo);
      end
      for (int i = 0; i < 12; i++) begin
         o = 3'($urandom_range(4, 5));
         y = pick();
         if (y == 0) y = 32'd3;
         do_op(o, pick(), y, lat, bc);
         n_cmp++;
         if ({lat, div_by_zero, hi, lo} !== {32'd33, 1'b0, hi_m, lo_m}) begin
            n_fail++;
            $display("FAIL div_rand op=%0d: got lat=%0d dbz=%b %h_%h want lat=33 dbz=0 %h_%h",
                     o, lat, div_by_zero, hi, lo, hi_m, lo_m);
         end
      end
`else
      for (int i = 0; i < 6; i++) begin
         o = 3'($urandom_range(4, 5));
         y = $urandom | 32'h1;
         do_op(o, $urandom, y, lat, bc);
         n_cmp++;
         if ({lat, bc, div_by_zero, hi, lo} !== {32'd0, 32'd0, 1'b1, hi_m, lo_m}) begin
            n_fail++;
            $display("FAIL div_disabled op=%0d: got lat=%0d busy=%0d dbz=%b %h_%h want 0 0 1 %h_%h",
                     o, lat, bc, div_by_zero, hi, lo, hi_m, lo_m);
         end
      end
`endif
   endtask

   task automatic test_div_zero();
      int lat, bc;
      do_op(3'd6, 32'h11, 32'h0, lat, bc);
      do_op(3'd7, 32'h22, 32'h0, lat, bc);
      for (int k = 4; k <= 5; k++) begin
         do_op(3'(k), $urandom, 32'h0, lat, bc);
         n_cmp++;
         if ({lat, bc, done, div_by_zero, dbz_m} !== {32'd0, 32'd0, 3'b111}) begin
            n_fail++;
            $display("FAIL divzero_resp op=%0d: got lat=%0d busy=%0d done=%b dbz=%b want 0 0 1 1",
                     k, lat, bc, done, div_by_zero);
         end
         n_cmp++;
         if ({hi, lo} !== {32'h11, 32'h22}) begin
            n_fail++; $display("FAIL divzero_hilo: got hi=%h lo=%h want 11 22", hi, lo);
         end
         @(posedge clk);
         #1;
         n_cmp++;
         if ({done, div_by_zero} !== 2'b00) begin
            n_fail++;
            $display("FAIL divzero_pulse: got done=%b dbz=%b want 0 0", done, div_by_zero);
         end
      end
   endtask

   task automatic test_back_to_back();
      int          lat, bc;
      logic [31:0] x, y, z;
      x = $urandom;
      y = $urandom;
      issue(3'd1, x, y);
      model(3'd1, x, y);
      repeat (5) @(posedge clk);
      z = ~lo_m;
      @(negedge clk);
      start = 1'b1; op = 3'd7; a = z;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat, bc);
      n_cmp++;
      if ({done, hi, lo} !== {1'b1, hi_m, lo_m}) begin
         n_fail++;
         $display("FAIL busy_ignore: got done=%b %h_%h want 1 %h_%h", done, hi, lo, hi_m, lo_m);
      end
      // Issue in the done cycle: must be accepted straight away
      x = pick();
      y = pick();
      issue(3'd0, x, y);
      n_cmp++;
      if ({busy, done} !== 2'b10) begin
         n_fail++; $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", busy, done);
      end
      wait_done(lat, bc);
      model(3'd0, x, y);
      n_cmp++;
      if ({lat, hi, lo} !== {32'd33, hi_m, lo_m}) begin
         n_fail++;
         $display("FAIL b2b_result: got lat=%0d %h_%h want 33 %h_%h", lat, hi, lo, hi_m, lo_m);
      end
      z = $urandom;
      do_op(3'd6, z, 32'h0, lat, bc);
      n_cmp++;
      if ({lat, done, hi, lo} !== {32'd0, 1'b1, hi_m, lo_m}) begin
         n_fail++;
         $display("FAIL b2b_move: got lat=%0d done=%b %h_%h want 0 1 %h_%h",
                  lat, done, hi, lo, hi_m, lo_m);
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_madd();
      test_div();
      test_div_zero();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
